// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, state encoding and width helper for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((64'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake signals of the transmit arbiter.
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
    import uart_arb_pkg::*;

    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ*BYTE_W-1:0] req_dat_i;
    logic [NREQ-1:0]        req_last_i;
    logic [NREQ-1:0]        req_ack_o;
    logic [NREQ-1:0]        grant_o;
    logic                   uart_wr_o;
    logic [BYTE_W-1:0]      uart_dat_o;
    logic                   uart_busy_i;
    logic                   err_o;
    logic                   err_clr_i;

    modport slave (
        input  req_valid_i, req_dat_i, req_last_i, uart_busy_i, err_clr_i,
        output req_ack_o, grant_o, uart_wr_o, uart_dat_o, err_o
    );

    modport master (
        output req_valid_i, req_dat_i, req_last_i, uart_busy_i, err_clr_i,
        input  req_ack_o, grant_o, uart_wr_o, uart_dat_o, err_o
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index strictly after the pointer.
module uart_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_o
);
    always_comb begin
        int j;
        j         = 0;
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            j = (int'(ptr_i) + i) % NREQ;
            if (!any_o && valid_i[IDX_W'(j)]) begin
                any_o     = 1'b1;
                win_idx_o = IDX_W'(j);
                win_oh_o  = NREQ'(1) << IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-write UART among NREQ producers,
// with packet locking and write/busy handshake sequencing.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int ARM_TIMEOUT  = 8,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_n_i,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IDX_W = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int TMAX  = (LOCK_TIMEOUT > ARM_TIMEOUT) ? LOCK_TIMEOUT : ARM_TIMEOUT;
    localparam int CNT_W = clog2(TMAX + 1);
    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              lock_q, lock_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [BYTE_W-1:0] dat_q, dat_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              go_issue;
    logic              err_set;
    logic [IDX_W-1:0]  issue_idx;

    uart_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .valid_i   (bus.req_valid_i),
        .ptr_i     (rr_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        dat_d     = dat_q;
        wr_d      = 1'b0;
        ack_d     = '0;
        err_set   = 1'b0;
        go_issue  = 1'b0;
        issue_idx = owner_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any && !bus.uart_busy_i) begin
                    go_issue  = 1'b1;
                    issue_idx = pick_idx;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_HI;
                cnt_d   = '0;
            end
            ST_WAIT_HI: begin
                if (bus.uart_busy_i) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == ARM_LAST) begin
                    err_set = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!bus.uart_busy_i) begin
                    if (!lock_q) begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else if (bus.req_valid_i[owner_q]) begin
                        go_issue = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_HOLD: begin
                // Locked owner keeps the grant; give up silently if it stays quiet.
                if (bus.req_valid_i[owner_q] && !bus.uart_busy_i) begin
                    go_issue = 1'b1;
                end else if (cnt_q == LOCK_LAST) begin
                    lock_d  = 1'b0;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so the write strobe and ack land in the ISSUE cycle.
        if (go_issue) begin
            state_d = ST_ISSUE;
            owner_d = issue_idx;
            rr_d    = issue_idx;
            grant_d = NREQ'(1) << issue_idx;
            ack_d   = NREQ'(1) << issue_idx;
            wr_d    = 1'b1;
            dat_d   = bus.req_dat_i[int'(issue_idx)*BYTE_W +: BYTE_W];
            lock_d  = ~bus.req_last_i[issue_idx];
        end

        err_d = err_set | (err_q & ~bus.err_clr_i);
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= IDX_W'(NREQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.req_ack_o  = ack_q;
    assign bus.uart_wr_o  = wr_q;
    assign bus.uart_dat_o = dat_q;
    assign bus.err_o      = err_q;
endmodule
